// File: rtl/core_launch_master.sv
// AXI4-Lite master that runs the core controller launch sequence from fabric.
// Ports:
//   M_AXI_ACLK / M_AXI_ARSTN : clock, synchronous active-low reset
//   START, MEM_ADDR          : launch request and program address
//   BUSY, DONE, ERROR        : sequence status back to the requester
//   M_AXI_AW*/W*/B*/AR*/R*   : AXI4-Lite master channels to the controller
module core_launch_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 16,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = 16'h0000,
    parameter int C_POLL_INTERVAL = 16,
    parameter int C_POLL_LIMIT = 1000000
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARSTN,
    input  logic                            START,
    input  logic [31:0]                     MEM_ADDR,
    output logic                            BUSY,
    output logic                            DONE,
    output logic                            ERROR,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_ADDR = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_RESP = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;
    localparam logic [2:0] S_FIN     = 3'd6;

    localparam logic [2:0] ST_POLL = 3'd4;
    localparam logic [2:0] ST_EXEC0 = 3'd5;

    logic [2:0]  state;
    logic [2:0]  step;
    logic        aw_done;
    logic        w_done;
    logic [31:0] mem_q;
    logic [31:0] poll_cnt;
    logic [31:0] wait_cnt;
    logic        error_q;

    logic [AW-1:0] wr_off;
    logic [31:0]   wr_val;
    logic          aw_hs;
    logic          w_hs;
    logic          aw_ok;
    logic          w_ok;
    logic [31:0]   poll_nxt;
    logic          limit_hit;
    logic          wait_last;
    logic          unused_rdata;

    // Register offset and payload for the write issued at each step.
    always_comb begin
        wr_off = '0;
        wr_val = '0;
        case (step)
            3'd0: wr_val = 32'd1;
            3'd2: begin
                wr_off = AW'(8);
                wr_val = mem_q;
            end
            3'd3: begin
                wr_off = AW'(4);
                wr_val = 32'd1;
            end
            3'd5: wr_off = AW'(4);
            default: ;
        endcase
    end

    assign M_AXI_AWVALID = (state == S_WR_ADDR) && !aw_done;
    assign M_AXI_WVALID  = (state == S_WR_ADDR) && !w_done;
    assign M_AXI_BREADY  = (state == S_WR_RESP);
    assign M_AXI_ARVALID = (state == S_RD_ADDR);
    assign M_AXI_RREADY  = (state == S_RD_RESP);

    // Payload buses are forced low outside their phase so reset reads as 0.
    assign M_AXI_AWADDR = (state == S_WR_ADDR) ? C_BASE_ADDR + wr_off : '0;
    assign M_AXI_WDATA  = (state == S_WR_ADDR) ? DW'(wr_val) : '0;
    assign M_AXI_ARADDR = (state == S_RD_ADDR) ? C_BASE_ADDR + AW'(12) : '0;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = '1;

    assign BUSY  = (state != S_IDLE) && (state != S_FIN);
    assign DONE  = (state == S_FIN);
    assign ERROR = error_q;

    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
    assign aw_ok = aw_done || aw_hs;
    assign w_ok  = w_done || w_hs;

    assign poll_nxt  = poll_cnt + 32'd1;
    assign limit_hit = (C_POLL_LIMIT != 0) && (poll_nxt == 32'(C_POLL_LIMIT));
    assign wait_last = (wait_cnt == 32'(C_POLL_INTERVAL - 1));

    assign unused_rdata = ^M_AXI_RDATA[DW-1:1];

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARSTN) begin
            state    <= S_IDLE;
            step     <= 3'd0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            mem_q    <= '0;
            poll_cnt <= '0;
            wait_cnt <= '0;
            error_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (START) begin
                        mem_q   <= MEM_ADDR;
                        error_q <= 1'b0;
                        step    <= 3'd0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= S_WR_ADDR;
                    end
                end
                S_WR_ADDR: begin
                    aw_done <= aw_ok;
                    w_done  <= w_ok;
                    if (aw_ok && w_ok) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        if (M_AXI_BRESP != 2'b00) begin
                            error_q <= 1'b1;
                            state   <= S_FIN;
                        end else if (step == ST_EXEC0) begin
                            state <= S_FIN;
                        end else if (step == 3'd3) begin
                            step     <= ST_POLL;
                            poll_cnt <= '0;
                            state    <= S_RD_ADDR;
                        end else begin
                            step  <= step + 3'd1;
                            state <= S_WR_ADDR;
                        end
                    end
                end
                S_RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        state <= S_RD_RESP;
                    end
                end
                S_RD_RESP: begin
                    if (M_AXI_RVALID) begin
                        // Any exit from polling still clears exec.
                        if (M_AXI_RRESP != 2'b00) begin
                            error_q <= 1'b1;
                            step    <= ST_EXEC0;
                            state   <= S_WR_ADDR;
                        end else if (M_AXI_RDATA[0]) begin
                            step  <= ST_EXEC0;
                            state <= S_WR_ADDR;
                        end else begin
                            poll_cnt <= poll_nxt;
                            if (limit_hit) begin
                                error_q <= 1'b1;
                                step    <= ST_EXEC0;
                                state   <= S_WR_ADDR;
                            end else begin
                                wait_cnt <= '0;
                                state    <= S_WAIT;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 32'd1;
                    if (wait_last) begin
                        state <= S_RD_ADDR;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_launch_master.sv
// Self-checking bench for core_launch_master: AXI-Lite slave model with
// randomized latencies, compared against a transaction-level launch model.
module tb_core_launch_master;

    localparam int LIMIT = 5;
    localparam int IVL   = 16;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        start;
    logic [31:0] mem_addr;
    logic        busy, done, error;
    logic [15:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;

    core_launch_master #(
        .C_POLL_INTERVAL(IVL),
        .C_POLL_LIMIT(LIMIT)
    ) dut (
        .M_AXI_ACLK(clk),
        .M_AXI_ARSTN(rstn),
        .START(start),
        .MEM_ADDR(mem_addr),
        .BUSY(busy),
        .DONE(done),
        .ERROR(error),
        .M_AXI_AWADDR(awaddr),
        .M_AXI_AWPROT(awprot),
        .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata),
        .M_AXI_WSTRB(wstrb),
        .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp),
        .M_AXI_BVALID(bvalid),
        .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr),
        .M_AXI_ARPROT(arprot),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata),
        .M_AXI_RRESP(rresp),
        .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready)
    );

    // Slave knobs, set per case by the stimulus.
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int zeros_k = 0, werr_k = -1, rerr_k = -1, case_id = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave model ----------------
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    int b_cnt, r_cnt, wr_idx, rd_idx, b_hs = 0, sl_case = -1;
    bit b_wait, r_wait, got_a, got_w;
    logic [15:0] a_addr;
    logic [31:0] w_data, rtmp;
    txn_t obs_q[$];

    assign awready = awvalid && (aw_cnt >= aw_dly);
    assign wready  = wvalid && (w_cnt >= w_dly);
    assign arready = arvalid && (ar_cnt >= ar_dly);

    function automatic txn_t mk(logic wr, logic [15:0] a, logic [31:0] d);
        txn_t t;
        t.wr = wr;
        t.addr = a;
        t.data = d;
        return t;
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            bvalid <= 1'b0; rvalid <= 1'b0;
            bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
            b_wait = 0; r_wait = 0; got_a = 0; got_w = 0;
        end else begin
            if (case_id != sl_case) begin
                sl_case = case_id;
                wr_idx = 0; rd_idx = 0; b_hs = 0;
                obs_q.delete();
            end
            if (awvalid && awready) aw_cnt <= 0;
            else if (awvalid) aw_cnt <= aw_cnt + 1;
            if (wvalid && wready) w_cnt <= 0;
            else if (wvalid) w_cnt <= w_cnt + 1;
            if (arvalid && arready) ar_cnt <= 0;
            else if (arvalid) ar_cnt <= ar_cnt + 1;
            if (awvalid && awready) begin got_a = 1; a_addr = awaddr; end
            if (wvalid && wready) begin got_w = 1; w_data = wdata; end
            if (bvalid && bready) begin bvalid <= 1'b0; b_hs++; end
            if (b_wait) begin
                if (b_cnt == 0) begin bvalid <= 1'b1; b_wait = 0; end
                else b_cnt--;
            end
            if (got_a && got_w) begin
                obs_q.push_back(mk(1'b1, a_addr, w_data));
                bresp <= (wr_idx == werr_k) ? 2'b10 : 2'b00;
                wr_idx++;
                got_a = 0; got_w = 0;
                if (b_dly == 0) bvalid <= 1'b1;
                else begin b_wait = 1; b_cnt = b_dly - 1; end
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (r_wait) begin
                if (r_cnt == 0) begin rvalid <= 1'b1; r_wait = 0; end
                else r_cnt--;
            end
            if (arvalid && arready) begin
                obs_q.push_back(mk(1'b0, araddr, 32'h0));
                rtmp = $urandom();
                rtmp[0] = (rd_idx >= zeros_k);
                rdata <= rtmp;
                rresp <= (rd_idx == rerr_k) ? 2'b10 : 2'b00;
                rd_idx++;
                if (r_dly == 0) rvalid <= 1'b1;
                else begin r_wait = 1; r_cnt = r_dly - 1; end
            end
        end
    end

    // ---------------- channel monitor ----------------
    int mon_case = -1, aw_run = 0, w_run = 0;
    int aw_len_q[$], w_len_q[$], ar_rise_q[$];
    bit overlap, unstable, ar_prev, aw_pv, w_pv;
    logic [15:0] aw_pa;
    logic [31:0] w_pd;

    always @(negedge clk) begin
        if (case_id != mon_case) begin
            mon_case = case_id;
            aw_len_q.delete(); w_len_q.delete(); ar_rise_q.delete();
            overlap = 0; unstable = 0; aw_run = 0; w_run = 0;
        end
        if (awvalid) aw_run++;
        else if (aw_run != 0) begin aw_len_q.push_back(aw_run); aw_run = 0; end
        if (wvalid) w_run++;
        else if (w_run != 0) begin w_len_q.push_back(w_run); w_run = 0; end
        if (awvalid && aw_pv && awaddr != aw_pa) unstable = 1;
        if (wvalid && w_pv && wdata != w_pd) unstable = 1;
        aw_pv = awvalid; aw_pa = awaddr;
        w_pv = wvalid; w_pd = wdata;
        if (arvalid && !ar_prev) ar_rise_q.push_back(cyc);
        ar_prev = arvalid;
        if ((awvalid || wvalid || bready) && (arvalid || rready)) overlap = 1;
    end

    // ---------------- reference model and checks ----------------
    int n_chk = 0, n_fail = 0;
    txn_t exp_q[$];
    bit exp_err;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch sequence as a list of bus transactions: four setup writes,
    // status polls until bit0, a timeout or a read error, then exec clear.
    task automatic model(input logic [31:0] mem, input int zeros,
                         input int werr, input int rerr);
        logic [15:0] offs[4];
        logic [31:0] dats[4];
        int wi, k;
        offs[0] = 16'h0; dats[0] = 32'h1;
        offs[1] = 16'h0; dats[1] = 32'h0;
        offs[2] = 16'h8; dats[2] = mem;
        offs[3] = 16'h4; dats[3] = 32'h1;
        exp_q.delete();
        exp_err = 0;
        wi = 0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(1'b1, offs[i], dats[i]));
            if (wi == werr) begin exp_err = 1; return; end
            wi++;
        end
        k = 0;
        while (1) begin
            exp_q.push_back(mk(1'b0, 16'hC, 32'h0));
            if (k == rerr) begin exp_err = 1; break; end
            if (k >= zeros) break;
            k++;
            if (k == LIMIT) begin exp_err = 1; break; end
        end
        exp_q.push_back(mk(1'b1, 16'h4, 32'h0));
        if (wi == werr) exp_err = 1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctrl"},
              64'({awprot, arprot, busy, done, error, awvalid, wvalid,
                   bready, arvalid, rready}), 64'(0));
        check({tag, "_bus"}, {awaddr, araddr, wdata}, 64'(0));
    endtask

    task automatic run_case(input logic [31:0] mem, input int zeros,
                            input int werr, input int rerr,
                            input int awd, input int wd, input int bd,
                            input int ard, input int rd,
                            input bit pulse, input bit want_lat);
        int st, dn, nw, nr, mg;
        bit seen;
        aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd;
        zeros_k = zeros; werr_k = werr; rerr_k = rerr;
        case_id++;
        model(mem, zeros, werr, rerr);
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        mem_addr = mem;
        st = cyc;
        @(negedge clk);
        start = 1'b0;
        check("busy_start", 64'(busy), 64'(1));
        check("err_clr", 64'(error), 64'(0));
        seen = 0;
        dn = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                dn = cyc;
                start = 1'b0;
                break;
            end
            start = pulse ? ($urandom_range(0, 4) == 0) : 1'b0;
        end
        check("done_seen", 64'(seen), 64'(1));
        check("error", 64'(error), 64'(exp_err));
        check("busy_at_done", 64'(busy), 64'(0));
        @(negedge clk);
        check("done_pulse", 64'(done), 64'(0));
        check("err_sticky", 64'(error), 64'(exp_err));
        check("n_txn", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check($sformatf("txn%0d", i), 64'(obs_q[i]), 64'(exp_q[i]));
        nw = 0;
        nr = 0;
        foreach (exp_q[i]) begin
            if (exp_q[i].wr) nw++;
            else nr++;
        end
        check("b_hs", 64'(b_hs), 64'(nw));
        check("ar_rises", 64'(ar_rise_q.size()), 64'(nr));
        if (ar_rise_q.size() >= 2) begin
            mg = 1 << 30;
            for (int i = 1; i < ar_rise_q.size(); i++)
                if (ar_rise_q[i] - ar_rise_q[i-1] < mg)
                    mg = ar_rise_q[i] - ar_rise_q[i-1];
            check("poll_gap", 64'(mg >= IVL + 2), 64'(1));
        end
        check("aw_hold", 64'(aw_len_q.size() != 0 ? aw_len_q[0] : 0),
              64'(awd + 1));
        check("w_hold", 64'(w_len_q.size() != 0 ? w_len_q[0] : 0),
              64'(wd + 1));
        check("stable", 64'(unstable), 64'(0));
        check("chan_excl", 64'(overlap), 64'(0));
        if (want_lat) check("latency", 64'(dn - st + 1), 64'(14));
    endtask

    initial begin
        bit seen, any;
        int v, we, re;
        rstn = 1'b0;
        start = 1'b0;
        mem_addr = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rstn = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        run_case(32'h0000_1234, 0, -1, -1, 0, 0, 0, 0, 0, 0, 1);
        run_case(32'h0000_8000, 3, -1, -1, 0, 0, 0, 0, 0, 0, 0);
        run_case(32'h0000_0055, 0, -1, -1, 3, 0, 0, 0, 0, 0, 0);
        run_case(32'h0000_4444, 0, 2, -1, 0, 0, 0, 0, 0, 0, 0);
        run_case(32'h0000_4444, 0, -1, -1, 0, 0, 0, 0, 0, 0, 1);
        run_case(32'h0000_0077, 100, -1, -1, 0, 0, 0, 0, 0, 1, 0);

        // Reset while the exec=1 write is on the bus.
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        zeros_k = 0; werr_k = -1; rerr_k = -1;
        case_id++;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        mem_addr = 32'h0000_CAFE;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (awvalid && awaddr == 16'h4 && wdata == 32'h1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("rst_reach_step3", 64'(seen), 64'(1));
        rstn = 1'b0;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        rstn = 1'b1;
        any = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy) any = 1;
        end
        check("idle_after_rst", 64'(any), 64'(0));
        run_case(32'h0000_0BEE, 0, -1, -1, 0, 0, 0, 0, 0, 0, 1);

        for (int n = 0; n < 8; n++) begin
            v = $urandom_range(0, 7);
            we = (v < 5) ? v : -1;
            v = $urandom_range(0, 9);
            re = (v < 4) ? v : -1;
            run_case($urandom(), $urandom_range(0, 6), we, re,
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), n[0], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
